// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular byte FIFO.
// The serial line is registered; a byte popped from idle waits one cycle before its start bit.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 104,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  CLOCK_12M,
  input  logic                  RESET_N,
  input  logic [7:0]            tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   level
);

  localparam int              DEPTH = 1 << DEPTH_LOG2;
  localparam int              LW    = DEPTH_LOG2 + 1;
  localparam logic [LW-1:0]   FULL  = LW'(DEPTH);
  localparam logic [15:0]     LAST  = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                state, state_nx;
  logic [15:0]           cnt, cnt_nx;
  logic [2:0]            bit_idx, bit_nx;
  logic [7:0]            shift, shift_nx;
  logic                  loaded, loaded_nx;
  logic                  tx_nx;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop, last;

  assign tx_ready = (level != FULL) && RESET_N;
  assign push     = tx_valid && tx_ready;
  assign last     = (cnt == LAST);
  // A byte held in the shift register awaiting its start bit still counts as work.
  assign busy     = (state != IDLE) || loaded || (level != '0);

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    bit_nx    = bit_idx;
    shift_nx  = shift;
    loaded_nx = loaded;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (loaded) begin
          state_nx  = START;
          cnt_nx    = '0;
          loaded_nx = 1'b0;
        end else if (level != '0) begin
          pop       = 1'b1;
          shift_nx  = mem[rd_ptr];
          loaded_nx = 1'b1;
        end
      end
      START: begin
        if (last) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      DATA: begin
        if (last) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[7:1]};
          if (bit_idx == 3'd7) state_nx = STOP;
          else                 bit_nx   = bit_idx + 3'd1;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      STOP: begin
        if (last) begin
          cnt_nx = '0;
          // Chain straight into the next frame so queued bytes go out back-to-back.
          if (level != '0) begin
            pop      = 1'b1;
            shift_nx = mem[rd_ptr];
            state_nx = START;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
    endcase

    unique case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shift_nx[0];
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_12M) begin
    if (!RESET_N) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      loaded  <= 1'b0;
      tx      <= 1'b1;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      bit_idx <= bit_nx;
      loaded  <= loaded_nx;
      tx      <= tx_nx;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLOCK_12M) begin
    if (push) mem[wr_ptr] <= tx_data;
    shift <= shift_nx;
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four instances with different bit periods, a serial decoder per
// instance, and directed plus randomized scenarios checked against arithmetic expectations.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic       rst_n [4];
  logic [7:0] din   [4];
  logic       vld   [4];
  logic       rdy   [4];
  logic       txo   [4];
  logic       bsy   [4];
  logic [2:0] lvl   [4];

  uart_tx_fifo #(.CLK_DIV(104), .DEPTH_LOG2(2)) u0 (
    .CLOCK_12M(clk), .RESET_N(rst_n[0]), .tx_data(din[0]), .tx_valid(vld[0]),
    .tx_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]), .level(lvl[0]));
  uart_tx_fifo #(.CLK_DIV(4), .DEPTH_LOG2(2)) u1 (
    .CLOCK_12M(clk), .RESET_N(rst_n[1]), .tx_data(din[1]), .tx_valid(vld[1]),
    .tx_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]), .level(lvl[1]));
  uart_tx_fifo #(.CLK_DIV(2), .DEPTH_LOG2(2)) u2 (
    .CLOCK_12M(clk), .RESET_N(rst_n[2]), .tx_data(din[2]), .tx_valid(vld[2]),
    .tx_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]), .level(lvl[2]));
  uart_tx_fifo #(.CLK_DIV(8), .DEPTH_LOG2(2)) u3 (
    .CLOCK_12M(clk), .RESET_N(rst_n[3]), .tx_data(din[3]), .tx_valid(vld[3]),
    .tx_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]), .level(lvl[3]));

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         start;
  } frame_t;
  frame_t frames[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Mid-bit sampling receiver; start is the first post-edge sample with the line low.
  task automatic mon(input int i, input int d);
    frame_t f;
    int     s;
    forever begin
      step();
      if (txo[i] === 1'b0) begin
        s = cyc;
        for (int j = 0; j < 8; j++) begin
          while (cyc < s + d + d / 2 + d * j) step();
          f.data[j] = txo[i];
        end
        while (cyc < s + 9 * d + d / 2) step();
        f.stop  = txo[i];
        f.start = s;
        frames.push_back(f);
      end
    end
  endtask

  function automatic logic [7:0] fdata(input int k);
    if (k < frames.size()) return frames[k].data;
    return 8'hxx;
  endfunction

  function automatic logic fstop(input int k);
    if (k < frames.size()) return frames[k].stop;
    return 1'bx;
  endfunction

  function automatic int fstart(input int k);
    if (k < frames.size()) return frames[k].start;
    return -1;
  endfunction

  task automatic push(input int i, input logic [7:0] b, output int when);
    logic r;
    when   = -1;
    din[i] = b;
    vld[i] = 1'b1;
    for (int k = 0; k < 400 && when < 0; k++) begin
      r = rdy[i];
      step();
      if (r) when = cyc;
    end
    vld[i] = 1'b0;
    chk("push accepted", (when >= 0) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic wait_frames(input int n, input int budget, input string tag);
    for (int k = 0; k < budget && frames.size() < n; k++) step();
    chk(tag, frames.size(), n);
  endtask

  task automatic wait_idle(input int i, input int budget, input string tag);
    for (int k = 0; k < budget && bsy[i] !== 1'b0; k++) step();
    chk(tag, 32'(bsy[i]), 32'd0);
  endtask

  initial begin
    int         n, s, w, idx, maxlvl, fall, d;
    int         acc [7];
    logic       e, r;
    logic [7:0] pat;
    logic [7:0] rb  [5];

    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0;
      vld[i]   = 1'b0;
      din[i]   = 8'h00;
    end
    fork
      mon(0, 104);
      mon(1, 4);
      mon(2, 2);
      mon(3, 8);
    join_none

    // Reset: writes attempted under reset must be ignored.
    repeat (2) step();
    vld[0] = 1'b1;
    din[0] = 8'h99;
    step();
    chk("reset level", 32'(lvl[0]), 32'd0);
    chk("reset busy", 32'(bsy[0]), 32'd0);
    chk("reset ready low", 32'(rdy[0]), 32'd0);
    for (int i = 0; i < 4; i++) chk("reset tx high", 32'(txo[i]), 32'd1);
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    #1;
    chk("ready after release", 32'(rdy[0]), 32'd1);

    // Single byte at 104 cycles per bit, first edge after reset release.
    din[0] = 8'h55;
    step();
    n      = cyc;
    vld[0] = 1'b0;
    chk("first write level", 32'(lvl[0]), 32'd1);
    chk("first write busy", 32'(bsy[0]), 32'd1);
    pat = 8'h55;
    for (int k = 1; k <= 1045; k++) begin
      step();
      d = cyc - n;
      if (d >= 2 && d <= 105)       e = 1'b0;
      else if (d >= 106 && d <= 937) e = pat[(d - 106) / 104];
      else                           e = 1'b1;
      chk("single tx waveform", 32'(txo[0]), 32'(e));
      chk("single busy", 32'(bsy[0]), (d < 1042) ? 32'd1 : 32'd0);
      if (d == 1) chk("single popped level", 32'(lvl[0]), 32'd0);
    end
    wait_frames(1, 10, "single frame count");
    chk("single data", 32'(fdata(0)), 32'h55);
    chk("single stop", 32'(fstop(0)), 32'd1);
    chk("single start edge", fstart(0), n + 2);

    // Burst fill at 4 cycles per bit.
    frames.delete();
    for (int j = 1; j <= 5; j++) push(1, 8'(j), acc[j]);
    for (int j = 2; j <= 5; j++) chk("burst accept edge", acc[j] - acc[1], j - 1);
    chk("burst full ready", 32'(rdy[1]), 32'd0);
    chk("burst full level", 32'(lvl[1]), 32'd4);
    push(1, 8'h06, acc[6]);
    chk("burst 6th accept edge", acc[6] - acc[1], 2 + 10 * 4 + 1);
    wait_frames(6, 400, "burst frame count");
    for (int j = 0; j < 6; j++) chk("burst order", 32'(fdata(j)), j + 1);
    wait_idle(1, 100, "burst drained");

    // Back-to-back frames are contiguous.
    frames.delete();
    push(1, 8'hA5, w);
    push(1, 8'h3C, w);
    fall = -1;
    for (int k = 0; k < 200 && fall < 0; k++) begin
      step();
      if (bsy[1] === 1'b0) fall = cyc;
    end
    wait_frames(2, 10, "b2b frame count");
    chk("b2b first", 32'(fdata(0)), 32'hA5);
    chk("b2b second", 32'(fdata(1)), 32'h3C);
    chk("b2b stop bits", 32'({fstop(0), fstop(1)}), 32'd3);
    chk("b2b no gap", fstart(1) - fstart(0), 40);
    chk("b2b activity span", fall - fstart(0), 80);

    // Blocked write while full during the stop bit of the current frame.
    frames.delete();
    for (int j = 0; j < 5; j++) rb[j] = 8'($urandom);
    push(1, rb[0], n);
    for (int j = 1; j < 5; j++) push(1, rb[j], w);
    s = n + 2;
    while (cyc < s + 36) step();
    din[1] = 8'hEE;
    vld[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      chk("blocked ready", 32'(rdy[1]), 32'd0);
      step();
      chk("blocked level", 32'(lvl[1]), 32'd4);
    end
    vld[1] = 1'b0;
    step();
    chk("blocked after pop", 32'(lvl[1]), 32'd3);
    push(1, 8'hEE, w);
    wait_frames(6, 400, "blocked frame count");
    for (int j = 0; j < 5; j++) chk("blocked kept order", 32'(fdata(j)), 32'(rb[j]));
    chk("blocked EE last", 32'(fdata(5)), 32'hEE);
    wait_idle(1, 100, "blocked drained");

    // Wrap-around at 2 cycles per bit with random valid gaps.
    frames.delete();
    idx    = 0;
    maxlvl = 0;
    for (int g = 0; g < 2000 && idx < 12; g++) begin
      vld[2] = ($urandom_range(0, 3) != 0);
      din[2] = 8'(idx);
      r      = rdy[2];
      chk("wrap ready rule", 32'(r), (lvl[2] != 3'd4) ? 32'd1 : 32'd0);
      step();
      if (vld[2] && r) idx++;
      if (int'(lvl[2]) > maxlvl) maxlvl = int'(lvl[2]);
    end
    vld[2] = 1'b0;
    chk("wrap all accepted", idx, 12);
    chk("wrap level bound", (maxlvl <= 4) ? 32'd1 : 32'd0, 32'd1);
    wait_frames(12, 600, "wrap frame count");
    for (int j = 0; j < 12; j++) chk("wrap order", 32'(fdata(j)), j);
    for (int j = 0; j < 12; j++) chk("wrap stop", 32'(fstop(j)), 32'd1);

    // Reset during data bit 3 at 8 cycles per bit.
    push(3, 8'($urandom), n);
    push(3, 8'($urandom), w);
    push(3, 8'($urandom), w);
    s = n + 2;
    while (cyc < s + 35) step();
    rst_n[3] = 1'b0;
    #1;
    chk("midreset ready low", 32'(rdy[3]), 32'd0);
    step();
    chk("midreset tx", 32'(txo[3]), 32'd1);
    chk("midreset level", 32'(lvl[3]), 32'd0);
    chk("midreset busy", 32'(bsy[3]), 32'd0);
    rst_n[3] = 1'b1;
    for (int k = 0; k < 150; k++) begin
      step();
      chk("post reset tx idle", 32'(txo[3]), 32'd1);
      chk("post reset not busy", 32'(bsy[3]), 32'd0);
    end
    frames.delete();
    push(3, 8'hF0, w);
    wait_frames(1, 200, "post reset frame count");
    chk("post reset data", 32'(fdata(0)), 32'hF0);
    chk("post reset stop", 32'(fstop(0)), 32'd1);
    repeat (100) step();
    chk("no stale frames", frames.size(), 1);
    chk("post reset idle", 32'(bsy[3]), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
